// File: rtl/pol_mem_xbar.sv
// pol_mem_xbar: address/read-data crossbar between pooling-core requesters
// and GLB bank ports.
//
// Address path (zero latency): each requester address is decoded to the
// lowest-numbered bank whose [CfgAddrMin, CfgAddrMax) range contains it.
// A per-bank round-robin arbiter picks one requester. The bank-local
// address (addr - CfgAddrMin) is presented on BnkAddr. The winning requester
// index is pushed into that bank's tag FIFO on each BnkAddr handshake.
//
// Return path: for each requester, a per-requester round-robin arbiter
// picks among banks whose data is valid and whose FIFO head tag names that
// requester. Bank data arriving with an empty tag FIFO is dropped as orphan.
//
// Ports:
//   clk, rst (sync, active-high), Clr (sync soft flush)
//   CfgAddrMin/CfgAddrMax : per-bank inclusive/exclusive address bounds
//   ReqAddrVld/Rdy, ReqAddr : requester address channel
//   BnkAddrVld/Rdy, BnkAddr : bank address channel
//   BnkOfmVld/Rdy, BnkOfm   : bank read-data channel
//   ReqOfmVld/Rdy, ReqOfm   : requester read-data channel
//   ErrFlag : sticky; bit0 unmapped address, bit1 orphan bank data
//   PerfGntCnt : per-bank address-handshake counters, present only when
//                POL_MEM_XBAR_PERF_EN is defined
module pol_mem_xbar #(
  parameter int NUM_REQ    = 6,
  parameter int NUM_BANK   = 6,
  parameter int IDX_WIDTH  = 10,
  parameter int DATA_WIDTH = 512,
  parameter int TAG_DEPTH  = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           Clr,
  input  logic [IDX_WIDTH*NUM_BANK-1:0]  CfgAddrMin,
  input  logic [IDX_WIDTH*NUM_BANK-1:0]  CfgAddrMax,
  input  logic [NUM_REQ-1:0]             ReqAddrVld,
  output logic [NUM_REQ-1:0]             ReqAddrRdy,
  input  logic [IDX_WIDTH*NUM_REQ-1:0]   ReqAddr,
  output logic [NUM_BANK-1:0]            BnkAddrVld,
  input  logic [NUM_BANK-1:0]            BnkAddrRdy,
  output logic [IDX_WIDTH*NUM_BANK-1:0]  BnkAddr,
  input  logic [NUM_BANK-1:0]            BnkOfmVld,
  output logic [NUM_BANK-1:0]            BnkOfmRdy,
  input  logic [DATA_WIDTH*NUM_BANK-1:0] BnkOfm,
  output logic [NUM_REQ-1:0]             ReqOfmVld,
  input  logic [NUM_REQ-1:0]             ReqOfmRdy,
  output logic [DATA_WIDTH*NUM_REQ-1:0]  ReqOfm,
  output logic [1:0]                     ErrFlag
`ifdef POL_MEM_XBAR_PERF_EN
  ,
  output logic [32*NUM_BANK-1:0]         PerfGntCnt
`endif
);

  localparam int RW = (NUM_REQ  > 1) ? $clog2(NUM_REQ)  : 1;
  localparam int BW = (NUM_BANK > 1) ? $clog2(NUM_BANK) : 1;
  localparam int PW = $clog2(TAG_DEPTH);
  localparam int CW = PW + 1;

  function automatic logic [RW-1:0] inc_req(input logic [RW-1:0] x);
    return (int'(x) >= NUM_REQ - 1) ? RW'(0) : RW'(x + RW'(1));
  endfunction

  function automatic logic [BW-1:0] inc_bank(input logic [BW-1:0] x);
    return (int'(x) >= NUM_BANK - 1) ? BW'(0) : BW'(x + BW'(1));
  endfunction

  logic                flush_s;
  logic [NUM_REQ-1:0]  mapped_s;
  logic [BW-1:0]       dec_bank_s [NUM_REQ];
  logic [RW-1:0]       addr_ptr_r [NUM_BANK];
  logic [RW-1:0]       addr_win_s [NUM_BANK];
  logic [NUM_BANK-1:0] addr_win_vld_s;
  logic [RW-1:0]       tag_mem_r  [NUM_BANK][TAG_DEPTH];
  logic [PW-1:0]       tag_rd_r   [NUM_BANK];
  logic [PW-1:0]       tag_wr_r   [NUM_BANK];
  logic [CW-1:0]       tag_cnt_r  [NUM_BANK];
  logic [RW-1:0]       tag_head_s [NUM_BANK];
  logic [NUM_BANK-1:0] tag_full_s;
  logic [NUM_BANK-1:0] tag_empty_s;
  logic [NUM_BANK-1:0] push_s;
  logic [NUM_BANK-1:0] pop_s;
  logic [NUM_BANK-1:0] orphan_s;
  logic [BW-1:0]       ret_ptr_r  [NUM_REQ];
  logic [BW-1:0]       ret_win_s  [NUM_REQ];
  logic [NUM_REQ-1:0]  ret_win_vld_s;
  logic [1:0]          err_r;

  assign flush_s = rst | Clr;
  assign ErrFlag = err_r;

  // Address decode: lowest bank whose range contains the address wins.
  always_comb begin
    logic [IDX_WIDTH-1:0] a, lo, hi;
    logic                 hit, m;
    logic [BW-1:0]        d;
    a = '0; lo = '0; hi = '0; hit = 1'b0; m = 1'b0; d = '0;
    mapped_s = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      a = ReqAddr[r*IDX_WIDTH +: IDX_WIDTH];
      m = 1'b0;
      d = '0;
      for (int b = 0; b < NUM_BANK; b++) begin
        lo  = CfgAddrMin[b*IDX_WIDTH +: IDX_WIDTH];
        hi  = CfgAddrMax[b*IDX_WIDTH +: IDX_WIDTH];
        hit = (a >= lo) && (a < hi);
        d   = (hit && !m) ? BW'(b) : d;
        m   = m | hit;
      end
      mapped_s[r]   = m;
      dec_bank_s[r] = d;
    end
  end

  // Per-bank round-robin over requesters decoded to that bank.
  always_comb begin
    int            idx;
    logic [RW-1:0] ix, w;
    logic          found, cand;
    idx = 0; ix = '0; w = '0; found = 1'b0; cand = 1'b0;
    for (int b = 0; b < NUM_BANK; b++) begin
      found = 1'b0;
      w     = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
        idx   = int'(addr_ptr_r[b]) + k;
        idx   = (idx >= NUM_REQ) ? idx - NUM_REQ : idx;
        ix    = RW'(idx);
        cand  = ReqAddrVld[ix] && mapped_s[ix] && (dec_bank_s[ix] == BW'(b));
        w     = (cand && !found) ? ix : w;
        found = found | cand;
      end
      addr_win_s[b]     = w;
      addr_win_vld_s[b] = found;
    end
  end

  // Tag FIFO status and head tag.
  always_comb begin
    for (int b = 0; b < NUM_BANK; b++) begin
      tag_full_s[b]  = (tag_cnt_r[b] == CW'(TAG_DEPTH));
      tag_empty_s[b] = (tag_cnt_r[b] == CW'(0));
      tag_head_s[b]  = tag_mem_r[b][tag_rd_r[b]];
    end
  end

  // Bank address channel and requester address ready.
  always_comb begin
    logic [IDX_WIDTH-1:0] sel;
    logic [NUM_REQ-1:0]   rdy;
    logic                 vld;
    sel = '0; rdy = '0; vld = 1'b0;
    BnkAddrVld = '0;
    BnkAddr    = '0;
    push_s     = '0;
    for (int b = 0; b < NUM_BANK; b++) begin
      sel = '0;
      for (int r = 0; r < NUM_REQ; r++) begin
        sel = (addr_win_s[b] == RW'(r)) ? ReqAddr[r*IDX_WIDTH +: IDX_WIDTH] : sel;
      end
      // A full tag FIFO blocks issue even if a pop happens this cycle.
      vld = !flush_s && addr_win_vld_s[b] && !tag_full_s[b];
      BnkAddrVld[b] = vld;
      BnkAddr[b*IDX_WIDTH +: IDX_WIDTH] = sel - CfgAddrMin[b*IDX_WIDTH +: IDX_WIDTH];
      push_s[b] = vld && BnkAddrRdy[b];
      for (int r = 0; r < NUM_REQ; r++) begin
        rdy[r] = rdy[r] | (push_s[b] && (addr_win_s[b] == RW'(r)));
      end
    end
    ReqAddrRdy = rdy;
  end

  // Per-requester round-robin over banks whose head tag names it.
  always_comb begin
    int            idx;
    logic [BW-1:0] ix, w;
    logic          found, cand;
    idx = 0; ix = '0; w = '0; found = 1'b0; cand = 1'b0;
    for (int r = 0; r < NUM_REQ; r++) begin
      found = 1'b0;
      w     = '0;
      for (int k = 0; k < NUM_BANK; k++) begin
        idx   = int'(ret_ptr_r[r]) + k;
        idx   = (idx >= NUM_BANK) ? idx - NUM_BANK : idx;
        ix    = BW'(idx);
        cand  = BnkOfmVld[ix] && !tag_empty_s[ix] && (tag_head_s[ix] == RW'(r));
        w     = (cand && !found) ? ix : w;
        found = found | cand;
      end
      ret_win_s[r]     = w;
      ret_win_vld_s[r] = found;
    end
  end

  // Read-data routing, bank ready, FIFO pop and orphan detection.
  always_comb begin
    logic [DATA_WIDTH-1:0] d;
    logic [RW-1:0]         h;
    logic                  granted, rdy;
    d = '0; h = '0; granted = 1'b0; rdy = 1'b0;
    ReqOfm    = '0;
    ReqOfmVld = '0;
    BnkOfmRdy = '0;
    orphan_s  = '0;
    pop_s     = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      d = '0;
      for (int b = 0; b < NUM_BANK; b++) begin
        d = (ret_win_s[r] == BW'(b)) ? BnkOfm[b*DATA_WIDTH +: DATA_WIDTH] : d;
      end
      ReqOfm[r*DATA_WIDTH +: DATA_WIDTH] = d;
      ReqOfmVld[r] = !flush_s && ret_win_vld_s[r];
    end
    for (int b = 0; b < NUM_BANK; b++) begin
      h           = tag_head_s[b];
      granted     = !tag_empty_s[b] && BnkOfmVld[b] && ret_win_vld_s[h] &&
                    (ret_win_s[h] == BW'(b));
      orphan_s[b] = BnkOfmVld[b] && tag_empty_s[b];
      // Orphan data is always accepted so the bank never stalls on it.
      rdy          = !flush_s && (granted ? ReqOfmRdy[h] : orphan_s[b]);
      BnkOfmRdy[b] = rdy;
      pop_s[b]     = BnkOfmVld[b] && rdy && !tag_empty_s[b];
    end
  end

  // Tag FIFO pointers and occupancy; flush discards in-flight tags.
  always_ff @(posedge clk) begin
    for (int b = 0; b < NUM_BANK; b++) begin
      if (flush_s) begin
        tag_rd_r[b]  <= '0;
        tag_wr_r[b]  <= '0;
        tag_cnt_r[b] <= '0;
      end else begin
        tag_rd_r[b]  <= tag_rd_r[b] + PW'(pop_s[b]);
        tag_wr_r[b]  <= tag_wr_r[b] + PW'(push_s[b]);
        tag_cnt_r[b] <= tag_cnt_r[b] + CW'(push_s[b]) - CW'(pop_s[b]);
      end
    end
  end

  // Tag storage; contents are qualified by occupancy so no reset is needed.
  always_ff @(posedge clk) begin
    for (int b = 0; b < NUM_BANK; b++) begin
      if (push_s[b]) begin
        tag_mem_r[b][tag_wr_r[b]] <= addr_win_s[b];
      end
    end
  end

  // Round-robin pointers advance past the winner only on a handshake.
  always_ff @(posedge clk) begin
    for (int b = 0; b < NUM_BANK; b++) begin
      if (flush_s) begin
        addr_ptr_r[b] <= '0;
      end else if (push_s[b]) begin
        addr_ptr_r[b] <= inc_req(addr_win_s[b]);
      end
    end
    for (int r = 0; r < NUM_REQ; r++) begin
      if (flush_s) begin
        ret_ptr_r[r] <= '0;
      end else if (ReqOfmVld[r] && ReqOfmRdy[r]) begin
        ret_ptr_r[r] <= inc_bank(ret_win_s[r]);
      end
    end
  end

  // Sticky error flags.
  always_ff @(posedge clk) begin
    if (flush_s) begin
      err_r <= 2'b00;
    end else begin
      err_r <= err_r | {(|orphan_s), (|(ReqAddrVld & ~mapped_s))};
    end
  end

`ifdef POL_MEM_XBAR_PERF_EN
  logic [31:0] perf_cnt_r [NUM_BANK];

  // Grant counters survive Clr; only rst clears them.
  always_ff @(posedge clk) begin
    for (int b = 0; b < NUM_BANK; b++) begin
      if (rst) begin
        perf_cnt_r[b] <= 32'd0;
      end else if (push_s[b]) begin
        perf_cnt_r[b] <= perf_cnt_r[b] + 32'd1;
      end
    end
  end

  // Flatten counters onto the output port.
  always_comb begin
    PerfGntCnt = '0;
    for (int b = 0; b < NUM_BANK; b++) begin
      PerfGntCnt[b*32 +: 32] = perf_cnt_r[b];
    end
  end
`else
  // Performance counters are not built in this configuration.
`endif

endmodule

// File: doc/pol_mem_xbar.md
POL_MEM_XBAR -- requirements
Module: pol_mem_xbar

Interface
REQ-001 SHALL have parameters: NUM_REQ, default 6, number of pooling-core requesters; NUM_BANK, default 6, number of GLB bank ports; IDX_WIDTH, default 10, address width; DATA_WIDTH, default 512, Ofm word width; TAG_DEPTH, default 4, per-bank outstanding-tag FIFO depth (power of 2, >=2).
REQ-002 SHALL have ports, listed as name, direction, width, meaning:
- clk  in  1  sole clock; one clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- Clr  in  1  soft flush, synchronous, active-high.
- CfgAddrMin  in  IDX_WIDTH*NUM_BANK  per-bank inclusive lower address bound.
- CfgAddrMax  in  IDX_WIDTH*NUM_BANK  per-bank exclusive upper address bound.
- ReqAddrVld / ReqAddrRdy  in / out  NUM_REQ  requester address handshake.
- ReqAddr  in  IDX_WIDTH*NUM_REQ  requester address.
- BnkAddrVld / BnkAddrRdy  out / in  NUM_BANK  bank address handshake.
- BnkAddr  out  IDX_WIDTH*NUM_BANK  bank-local address.
- BnkOfmVld / BnkOfmRdy  in / out  NUM_BANK  bank read-data handshake.
- BnkOfm  in  DATA_WIDTH*NUM_BANK  bank read data.
- ReqOfmVld / ReqOfmRdy  out / in  NUM_REQ  requester read-data handshake.
- ReqOfm  out  DATA_WIDTH*NUM_REQ  read data routed to the requester.
- ErrFlag  out  2  sticky errors: bit0 unmapped address, bit1 orphan bank data.

Function
REQ-003 SHALL decode each ReqAddr to bank b where CfgAddrMin[b] <= addr < CfgAddrMax[b]; on overlapping ranges the lowest b SHALL win.
REQ-004 SHALL arbitrate, per bank, among valid requesters decoded to that bank with a round-robin arbiter; the pointer SHALL advance to winner+1 (mod NUM_REQ) only on a completed BnkAddr handshake, and SHALL hold otherwise.
REQ-005 SHALL drive BnkAddrVld[b] when a winner exists and tag FIFO b is not full; BnkAddr[b] SHALL equal ReqAddr[winner] - CfgAddrMin[b], truncated to IDX_WIDTH.
REQ-006 SHALL assert ReqAddrRdy[r] only when r is the winner of its bank and BnkAddrVld & BnkAddrRdy are both high for that bank; address path latency SHALL be zero cycles.
REQ-007 SHALL push the winner index into tag FIFO b on each bank address handshake.
REQ-008 SHALL never assert ReqAddrRdy for an unmapped address; the request SHALL stall, and ErrFlag[0] SHALL set while it is valid.
REQ-009 SHALL, per requester r, round-robin arbitrate among banks with BnkOfmVld high, tag FIFO non-empty, and head tag == r; ReqOfmVld[r] SHALL equal (any candidate) and ReqOfm[r] SHALL equal BnkOfm of the winner, combinationally.
REQ-010 SHALL drive BnkOfmRdy[b] = ReqOfmRdy[r] when bank b wins requester r; tag FIFO b SHALL pop on that handshake, and the return pointer of r SHALL advance to b+1 (mod NUM_BANK).
REQ-011 SHALL, when BnkOfmVld[b] is high with tag FIFO b empty, assert BnkOfmRdy[b] (drop the word) and set ErrFlag[1].
REQ-012 SHALL allow a push and a pop on the same tag FIFO in the same cycle, including when full (pop frees the slot only on the next cycle; full blocks the push that cycle).
REQ-013 SHALL preserve per-bank return order; a requester MAY receive data out of issue order across banks.

Reset
REQ-014 SHALL, on rst, empty all tag FIFOs, zero all round-robin pointers, and clear ErrFlag; all Vld/Rdy outputs SHALL be 0 while rst is high.
REQ-015 SHALL, on Clr, perform the same as rst except that performance counters hold; in-flight tags SHALL be discarded, and subsequent bank data SHALL be treated as orphan data.

Configuration
REQ-016 SHALL, with POL_MEM_XBAR_PERF_EN defined, add output PerfGntCnt (32*NUM_BANK), a per-bank count of address handshakes that wraps at 2^32 and is cleared by rst only; without the macro, the port and counters SHALL be absent and behaviour SHALL be otherwise identical.

Verification
REQ-017 Bank0 range [0,64), bank1 range [64,128); requester 2 sends addr 70 -> BnkAddr[1]=6 in the same cycle, and data from bank 1 SHALL return on ReqOfm[2].
REQ-018 Requesters 0, 1 and 3 each continuously request bank 0 -> grants SHALL go 0,1,3,0,1,3.
REQ-019 Four requests to bank 2 with TAG_DEPTH=4 and no return -> the fifth request SHALL be stalled; after one data pop, the fifth SHALL be granted one cycle later.
REQ-020 Requester 4 sends addr 200 with all ranges ending at 128 -> ReqAddrRdy[4]=0 indefinitely and ErrFlag=2'b01.
REQ-021 Clr with 2 tags outstanding, then bank data arrives -> BnkOfmRdy=1, no ReqOfmVld, and ErrFlag[1]=1.
